// File: rtl/motor_spd_sequencer_if.sv
// Command/speed bundle between the flight controller and the motor speed sequencer.
// The master is the flight-controller side and the slave is the sequencer.
interface motor_spd_sequencer_if;
  logic        cmd_vld;
  logic [10:0] frnt_cmd;
  logic [10:0] bck_cmd;
  logic [10:0] lft_cmd;
  logic [10:0] rght_cmd;
  logic        arm_req;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        armed;
  logic        fault;
  logic        upd;

  modport master (
    output cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd, arm_req,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, armed, fault, upd
  );

  modport slave (
    input  cmd_vld, frnt_cmd, bck_cmd, lft_cmd, rght_cmd, arm_req,
    output frnt_spd, bck_spd, lft_spd, rght_spd, armed, fault, upd
  );
endinterface

// File: rtl/motor_spd_sequencer.sv
// Arming FSM, command watchdog and per-frame slew limiter for four ESC speed outputs.
// Speeds move only on the frame tick; an operator kill zeroes them at once.
module motor_spd_sequencer #(
  parameter int          FRAME_CLKS = 1048576,
  parameter logic [10:0] SLEW       = 11'd64,
  parameter logic [10:0] ARM_THRESH = 11'd32,
  parameter int          ARM_TICKS  = 8,
  parameter int          WD_TICKS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  motor_spd_sequencer_if.slave bus
);
  localparam int DATA_W   = 11;
  localparam int CNT_W    = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
  localparam int ARM_CW   = $clog2(ARM_TICKS + 1);
  localparam int WD_CW    = $clog2(WD_TICKS + 1);
  localparam logic signed [DATA_W:0] SLEW_S = $signed({1'b0, SLEW});

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    frame_cnt;
  logic [ARM_CW-1:0]   arm_cnt, arm_cnt_nxt;
  logic [WD_CW-1:0]    wd_cnt, wd_cnt_nxt;
  logic [DATA_W-1:0]   cmd [4];
  logic [DATA_W-1:0]   tgt [4];
  logic [DATA_W-1:0]   spd [4];
  logic                upd_r;
  logic                tick;
  logic                all_low;
  logic                spd_nz;
  logic                qualify;
  logic                kill;

  // One step toward tgt, difference taken at 12 bits signed so no wrap is possible.
  function automatic logic [DATA_W-1:0] slew_step(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] goal);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
    if (diff > SLEW_S)
      return cur + SLEW;
    else if (diff < -SLEW_S)
      return cur - SLEW;
    else
      return goal;
  endfunction

  assign cmd[0] = bus.frnt_cmd;
  assign cmd[1] = bus.bck_cmd;
  assign cmd[2] = bus.lft_cmd;
  assign cmd[3] = bus.rght_cmd;

  assign tick    = (frame_cnt == CNT_W'(FRAME_CLKS - 1));
  assign all_low = (tgt[0] < ARM_THRESH) && (tgt[1] < ARM_THRESH) &&
                   (tgt[2] < ARM_THRESH) && (tgt[3] < ARM_THRESH);
  assign spd_nz  = (|spd[0]) || (|spd[1]) || (|spd[2]) || (|spd[3]);
  assign qualify = bus.arm_req && all_low;
  assign kill    = !bus.arm_req && ((state == ARMING) || (state == ARMED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (tick)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DISARMED;
      arm_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
      wd_cnt  <= wd_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    wd_cnt_nxt  = '0;
    unique case (state)
      DISARMED: begin
        arm_cnt_nxt = '0;
        if (tick && qualify)
          state_nxt = ARMING;
      end
      ARMING: begin
        if (!bus.arm_req) begin
          state_nxt   = DISARMED;
          arm_cnt_nxt = '0;
        end else if (tick) begin
          if (!qualify) begin
            state_nxt   = DISARMED;
            arm_cnt_nxt = '0;
          end else if (arm_cnt == ARM_CW'(ARM_TICKS - 1)) begin
            state_nxt   = ARMED;
            arm_cnt_nxt = '0;
          end else begin
            arm_cnt_nxt = arm_cnt + 1'b1;
          end
        end
      end
      ARMED: begin
        // A command arriving on the tick clock still counts as fresh.
        if (!bus.arm_req) begin
          state_nxt = DISARMED;
        end else if (bus.cmd_vld) begin
          wd_cnt_nxt = '0;
        end else if (tick) begin
          if (wd_cnt == WD_CW'(WD_TICKS - 1))
            state_nxt = FAULT;
          else
            wd_cnt_nxt = wd_cnt + 1'b1;
        end else begin
          wd_cnt_nxt = wd_cnt;
        end
      end
      FAULT: begin
        if (tick && !spd_nz && !bus.arm_req)
          state_nxt = DISARMED;
      end
      default: state_nxt = DISARMED;
    endcase
  end

  // Targets and slew-limited speed registers; new targets take effect from the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        tgt[i] <= '0;
        spd[i] <= '0;
      end
      upd_r <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (state == FAULT)
          tgt[i] <= '0;
        else if (bus.cmd_vld)
          tgt[i] <= cmd[i];

        if (kill || (state == DISARMED) || (state == ARMING))
          spd[i] <= '0;
        else if (tick && (state == ARMED))
          spd[i] <= slew_step(spd[i], tgt[i]);
        else if (tick && (state == FAULT))
          spd[i] <= slew_step(spd[i], '0);
      end
      upd_r <= kill ? spd_nz : (tick && ((state == ARMED) || (state == FAULT)));
    end
  end

  assign bus.frnt_spd = spd[0];
  assign bus.bck_spd  = spd[1];
  assign bus.lft_spd  = spd[2];
  assign bus.rght_spd = spd[3];
  assign bus.armed    = (state == ARMED);
  assign bus.fault    = (state == FAULT);
  assign bus.upd      = upd_r;
endmodule

// File: tb/tb_motor_spd_sequencer.sv
// Directed bench for motor_spd_sequencer with a 16-clock frame.
module tb_motor_spd_sequencer;
  localparam int FRAME = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edges = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  motor_spd_sequencer_if bus();

  motor_spd_sequencer #(
    .FRAME_CLKS(FRAME),
    .SLEW      (11'd64),
    .ARM_THRESH(11'd32),
    .ARM_TICKS (8),
    .WD_TICKS  (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f, b, l, r;
    int ef, eb, el, er;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    edges++;
    #1;
  endtask

  // Advance to 1 ns after the next tick edge (edges is a multiple of FRAME there).
  task automatic go_tick();
    do clk1(); while (edges % FRAME != 0);
  endtask

  task automatic step_tick(input bit v, input int f, input int b, input int l, input int r);
    if (v) begin
      bus.frnt_cmd = 11'(f);
      bus.bck_cmd  = 11'(b);
      bus.lft_cmd  = 11'(l);
      bus.rght_cmd = 11'(r);
      bus.cmd_vld  = 1'b1;
      clk1();
      bus.cmd_vld  = 1'b0;
    end
    go_tick();
  endtask

  task automatic arm_up(input string tag);
    for (int i = 1; i <= 9; i++) begin
      step_tick(1'b1, 10, 10, 10, 10);
      chk($sformatf("%s_armed_t%0d", tag, i), int'(bus.armed), (i == 9) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d edges", edges, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_l;
    vecs[0] = '{200, 100,   10,  0,  64, 64,  10,  0};
    vecs[1] = '{200, 100,   10,  0, 128, 100, 10,  0};
    vecs[2] = '{200, 100,   10,  0, 192, 100, 10,  0};
    vecs[3] = '{200, 100,   10,  0, 200, 100, 10,  0};
    vecs[4] = '{  0,  30, 1000, 64, 136, 36,  74, 64};
    vecs[5] = '{  0,  30, 1000, 64,  72, 30, 138, 64};
    vecs[6] = '{  0,  30, 1000, 64,   8, 30, 202, 64};
    vecs[7] = '{  0,  30, 1000, 64,   0, 30, 266, 64};

    bus.cmd_vld = 1'b0;
    bus.frnt_cmd = '0; bus.bck_cmd = '0; bus.lft_cmd = '0; bus.rght_cmd = '0;
    bus.arm_req = 1'b0;
    repeat (3) clk1();
    chk("rst_spd", int'(bus.frnt_spd | bus.bck_spd | bus.lft_spd | bus.rght_spd), 0);
    chk("rst_armed", int'(bus.armed), 0);
    chk("rst_fault", int'(bus.fault), 0);
    chk("rst_upd", int'(bus.upd), 0);
    rst_n = 1'b1;
    edges = 0;

    // Arming aborted by a high command at tick 4, then a full 8-tick count again.
    bus.arm_req = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step_tick(1'b1, (i == 4) ? 40 : 10, 10, 10, 10);
      chk($sformatf("arm_abort_t%0d", i), int'(bus.armed), (i == 13) ? 1 : 0);
    end

    for (int i = 0; i < 8; i++) begin
      step_tick(1'b1, vecs[i].f, vecs[i].b, vecs[i].l, vecs[i].r);
      chk($sformatf("vec%0d_f", i), int'(bus.frnt_spd), vecs[i].ef);
      chk($sformatf("vec%0d_b", i), int'(bus.bck_spd),  vecs[i].eb);
      chk($sformatf("vec%0d_l", i), int'(bus.lft_spd),  vecs[i].el);
      chk($sformatf("vec%0d_r", i), int'(bus.rght_spd), vecs[i].er);
      chk($sformatf("vec%0d_upd", i), int'(bus.upd), 1);
    end
    clk1();
    chk("upd_idle", int'(bus.upd), 0);

    // Two silent ticks, then cmd_vld on the tick clock itself.
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdA_l", int'(bus.lft_spd), 330);
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdB_l", int'(bus.lft_spd), 394);
    while (edges % FRAME != FRAME - 1) clk1();
    bus.frnt_cmd = 11'd100;
    bus.cmd_vld  = 1'b1;
    clk1();
    bus.cmd_vld  = 1'b0;
    chk("coinc_f_old_tgt", int'(bus.frnt_spd), 0);
    chk("coinc_l", int'(bus.lft_spd), 458);
    chk("coinc_fault", int'(bus.fault), 0);
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdD_f", int'(bus.frnt_spd), 64);
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdE_f", int'(bus.frnt_spd), 100);
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdF_fault", int'(bus.fault), 0);
    step_tick(1'b0, 0, 0, 0, 0);
    chk("wdG_fault", int'(bus.fault), 1);
    chk("wdG_armed", int'(bus.armed), 0);
    chk("wdG_l", int'(bus.lft_spd), 714);

    // Fault ramp-down toward zero, held in FAULT while arm_req stays high.
    step_tick(1'b1, 2000, 2000, 2000, 2000);
    chk("rampH_f", int'(bus.frnt_spd), 36);
    chk("rampH_b", int'(bus.bck_spd), 0);
    chk("rampH_l", int'(bus.lft_spd), 650);
    chk("rampH_r", int'(bus.rght_spd), 0);
    exp_l = 650;
    for (int i = 0; i < 11; i++) begin
      step_tick(1'b0, 0, 0, 0, 0);
      exp_l = (exp_l > 64) ? exp_l - 64 : 0;
      chk($sformatf("ramp%0d_l", i), int'(bus.lft_spd), exp_l);
      chk($sformatf("ramp%0d_upd", i), int'(bus.upd), 1);
    end
    step_tick(1'b0, 0, 0, 0, 0);
    chk("fault_hold", int'(bus.fault), 1);
    bus.arm_req = 1'b0;
    clk1();
    chk("fault_no_kill", int'(bus.fault), 1);
    go_tick();
    chk("fault_exit", int'(bus.fault), 0);

    // Kill between ticks with frnt_spd at 700.
    bus.arm_req = 1'b1;
    arm_up("arm2");
    for (int i = 0; i < 11; i++) step_tick(1'b1, 700, 0, 0, 0);
    chk("kill_pre_f", int'(bus.frnt_spd), 700);
    clk1();
    clk1();
    bus.arm_req = 1'b0;
    clk1();
    chk("kill_f", int'(bus.frnt_spd), 0);
    chk("kill_upd", int'(bus.upd), 1);
    chk("kill_armed", int'(bus.armed), 0);
    clk1();
    chk("kill_upd_drop", int'(bus.upd), 0);

    // Asynchronous reset while armed at 500.
    bus.arm_req = 1'b1;
    arm_up("arm3");
    for (int i = 0; i < 8; i++) step_tick(1'b1, 500, 500, 0, 0);
    chk("rst2_pre_f", int'(bus.frnt_spd), 500);
    #3 rst_n = 1'b0;
    #1;
    chk("rst2_f", int'(bus.frnt_spd), 0);
    chk("rst2_b", int'(bus.bck_spd), 0);
    chk("rst2_armed", int'(bus.armed), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
